// File: rtl/radar_pkg.sv
// Shared types and constants for the radar capture/serialize path.
// Holds the serializer state encoding and the ADC magnitude helper.
package radar_pkg;

    typedef enum logic [2:0] {CAPTURE, SYNC, START, LEAD, SHIFT} ser_state_e;

    localparam int ADC_MID        = 2048;
    localparam int WORD_W         = 12;
    localparam int FRAME_WORDS    = 2048;
    localparam int CLK_DIV        = 16;
    localparam int BIT_SER_CYCLES = 2;

    // |x - mid| at one extra bit, then clamped back to WORD_W bits
    function automatic logic [WORD_W-1:0] adc_mag(input logic [WORD_W-1:0] x);
        logic signed [WORD_W:0] d;
        logic        [WORD_W:0] a;
        d = $signed({1'b0, x}) - $signed((WORD_W+1)'(ADC_MID));
        a = d[WORD_W] ? $unsigned(-d) : $unsigned(d);
        return a[WORD_W] ? {WORD_W{1'b1}} : a[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/radar_serializer.sv
// Frame buffer plus SYNC/START/LEAD/SHIFT sequencer streaming words MSB first.
// Bits change on serial-clock rising edges; no backpressure, reset aborts a stream at once.
module radar_serializer
    import radar_pkg::*;
#(
    parameter int FRAME_WORDS    = radar_pkg::FRAME_WORDS,
    parameter int BIT_SER_CYCLES = radar_pkg::BIT_SER_CYCLES,
    parameter int AW             = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              div_rise_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_dat_i,
    output logic              busy_o,
    output logic              next_data_o,
    output logic              data_o
);

    localparam int PW = (BIT_SER_CYCLES > 1) ? $clog2(BIT_SER_CYCLES) : 1;
    localparam int BW = $clog2(WORD_W);

    logic [WORD_W-1:0] mem_q [FRAME_WORDS];

    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [PW-1:0]     per_q, per_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [AW-1:0]     word_q, word_d;
    logic [AW-1:0]     rd_addr;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_addr = (state_q == LEAD) ? '0 : word_q + 1'b1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        per_d   = per_q;
        bit_d   = bit_q;
        word_d  = word_q;
        case (state_q)
            CAPTURE: if (start_i)    state_d = SYNC;
            SYNC:    if (div_rise_i) state_d = START;
            START:   if (div_rise_i) state_d = LEAD;
            LEAD: begin
                if (div_rise_i) begin
                    state_d = SHIFT;
                    sh_d    = mem_q[rd_addr];
                    per_d   = '0;
                    bit_d   = '0;
                    word_d  = '0;
                end
            end
            SHIFT: begin
                if (div_rise_i) begin
                    if (per_q != PW'(BIT_SER_CYCLES - 1)) begin
                        per_d = per_q + 1'b1;
                    end else begin
                        per_d = '0;
                        if (bit_q != BW'(WORD_W - 1)) begin
                            bit_d = bit_q + 1'b1;
                            sh_d  = {sh_q[WORD_W-2:0], 1'b0};
                        end else begin
                            bit_d = '0;
                            if (word_q == AW'(FRAME_WORDS - 1)) begin
                                state_d = CAPTURE;
                            end else begin
                                word_d = word_q + 1'b1;
                                sh_d   = mem_q[rd_addr];
                            end
                        end
                    end
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CAPTURE;
            sh_q    <= '0;
            per_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            per_q   <= per_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
        end
    end

    assign busy_o      = (state_q != CAPTURE);
    assign next_data_o = (state_q == START);
    assign data_o      = (state_q == SHIFT) && sh_q[WORD_W-1];

endmodule

// File: rtl/radar_top.sv
// ADC sampling every 2nd clk, pairwise magnitude, frame capture and serial readout.
// Magnitudes update 1 clk after the odd sample; no backpressure, samples outside capture are dropped.
module radar_top
    import radar_pkg::*;
#(
    parameter int ADC_W          = 12,
    parameter int FRAME_WORDS    = radar_pkg::FRAME_WORDS,
    parameter int CLK_DIV        = radar_pkg::CLK_DIV,
    parameter int BIT_SER_CYCLES = radar_pkg::BIT_SER_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADC_W-1:0]             adc_in,
    output logic [radar_pkg::WORD_W-1:0] mag_out1,
    output logic [radar_pkg::WORD_W-1:0] mag_out2,
    output logic                         fft_next_out,
    output logic                         next_data,
    output logic                         data,
    output logic                         clk_div_16
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int AW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    logic [DIV_W-1:0]  div_q;
    logic              ph_q, smp_vld_q, odd_q, even_cap_q, fft_q;
    logic [ADC_W-1:0]  smp_q;
    logic [WORD_W-1:0] hold_q, mag1_q, mag2_q;
    logic [AW-1:0]     wr_ptr_q;

    logic [WORD_W-1:0] mag_now, wr_dat;
    logic              wr_en, frame_done, busy, div_rise;

    assign div_rise   = (div_q == DIV_W'(CLK_DIV / 2 - 1));
    assign mag_now    = adc_mag(WORD_W'(smp_q));
    assign wr_dat     = (hold_q > mag_now) ? hold_q : mag_now;
    // a pair is stored only if its even half also arrived while capturing
    assign wr_en      = smp_vld_q && odd_q && even_cap_q && !busy;
    assign frame_done = wr_en && (wr_ptr_q == AW'(FRAME_WORDS - 1));

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            div_q      <= '0;
            ph_q       <= 1'b0;
            smp_vld_q  <= 1'b0;
            odd_q      <= 1'b0;
            even_cap_q <= 1'b0;
            fft_q      <= 1'b0;
            smp_q      <= '0;
            hold_q     <= '0;
            mag1_q     <= '0;
            mag2_q     <= '0;
            wr_ptr_q   <= '0;
        end else begin
            div_q     <= div_q + 1'b1;
            ph_q      <= ~ph_q;
            smp_vld_q <= ph_q;
            fft_q     <= 1'b0;
            if (ph_q) begin
                smp_q <= adc_in;
            end
            if (smp_vld_q) begin
                odd_q <= ~odd_q;
                if (!odd_q) begin
                    hold_q     <= mag_now;
                    even_cap_q <= ~busy;
                end else begin
                    mag1_q <= hold_q;
                    mag2_q <= mag_now;
                end
            end
            if (wr_en) begin
                wr_ptr_q <= frame_done ? '0 : wr_ptr_q + 1'b1;
                fft_q    <= (wr_ptr_q == '0);
            end
        end
    end

    radar_serializer #(
        .FRAME_WORDS    (FRAME_WORDS),
        .BIT_SER_CYCLES (BIT_SER_CYCLES),
        .AW             (AW)
    ) u_ser (
        .clk_i       (clk),
        .rst_i       (reset_n),
        .start_i     (frame_done),
        .div_rise_i  (div_rise),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_ptr_q),
        .wr_dat_i    (wr_dat),
        .busy_o      (busy),
        .next_data_o (next_data),
        .data_o      (data)
    );

    assign clk_div_16   = div_q[DIV_W-1];
    assign mag_out1     = mag1_q;
    assign mag_out2     = mag2_q;
    assign fft_next_out = fft_q;

endmodule

// File: tb/tb_radar_top.sv
// Directed bench for radar_top with a 16-word frame to keep serial runs short.
module tb_radar_top;

    localparam int FW = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] adc_in;
    logic [11:0] mag_out1, mag_out2;
    logic        fft_next_out, next_data, data, clk_div_16;

    int n_chk = 0;
    int n_err = 0;
    int fft_cnt = 0;

    radar_top #(
        .ADC_W          (12),
        .FRAME_WORDS    (FW),
        .CLK_DIV        (16),
        .BIT_SER_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .adc_in       (adc_in),
        .mag_out1     (mag_out1),
        .mag_out2     (mag_out2),
        .fft_next_out (fft_next_out),
        .next_data    (next_data),
        .data         (data),
        .clk_div_16   (clk_div_16)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fft_next_out) fft_cnt <= fft_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-derived per-pair patterns: samples, expected magnitudes, stored word
    task automatic pat(input int mode, input int k,
                       output int e, output int o, output int m1, output int m2, output int w);
        case (mode)
            0: begin e = 2048; o = 2048; m1 = 0;    m2 = 0;    w = 0;    end
            1: begin e = 0;    o = 4095; m1 = 2048; m2 = 2047; w = 2048; end
            2: begin e = 2048 + k; o = 2048 + k; m1 = k; m2 = k; w = k;  end
            3: begin
                e  = 2048 + 97 * k;
                o  = (k % 2 == 1) ? 2048 - 131 * k : 2048 - 37 * k;
                m1 = 97 * k;
                m2 = (k % 2 == 1) ? 131 * k : 37 * k;
                w  = (k % 2 == 1) ? 131 * k : 97 * k;
            end
            default: begin e = 2148; o = 2148; m1 = 100; m2 = 100; w = 100; end
        endcase
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        adc_in  = 12'd2048;
        repeat (3) @(negedge clk);
        chk("rst_out", {mag_out1, mag_out2, fft_next_out, next_data, data, clk_div_16}, 0);
        reset_n = 1'b0;
    endtask

    // Starts at a pair boundary (right after reset release) and feeds FW pairs
    task automatic feed(input int mode);
        int e, o, m1, m2, w, pm1, pm2;
        pm1 = 0;
        pm2 = 0;
        for (int k = 0; k < FW; k++) begin
            pat(mode, k, e, o, m1, m2, w);
            adc_in = 12'(e);
            repeat (2) @(negedge clk);
            if (k > 0) begin
                chk($sformatf("mag1_m%0d_p%0d", mode, k - 1), mag_out1, pm1);
                chk($sformatf("mag2_m%0d_p%0d", mode, k - 1), mag_out2, pm2);
            end
            adc_in = 12'(o);
            repeat (2) @(negedge clk);
            pm1 = m1;
            pm2 = m2;
        end
        @(negedge clk);
        chk($sformatf("mag1_m%0d_last", mode), mag_out1, pm1);
        chk($sformatf("mag2_m%0d_last", mode), mag_out2, pm2);
    endtask

    task automatic wait_cdr();
        logic p;
        p = clk_div_16;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!p && clk_div_16) return;
            p = clk_div_16;
        end
        chk("cdiv_timeout", 0, 1);
    endtask

    task automatic wait_nd(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (next_data) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("nd_timeout", 0, 1);
    endtask

    task automatic rx(input int mode, input logic [11:0] post_adc);
        bit ok;
        int e, o, m1, m2, w, wd;
        logic [11:0] got;
        wait_nd(ok);
        if (!ok) return;
        wd = 0;
        while (next_data && wd < 40) begin
            wd++;
            @(negedge clk);
        end
        chk("nd_width", wd, 16);
        chk("lead_data", data, 0);
        wait_cdr();
        wait_cdr();
        #100;
        for (int j = 0; j < FW; j++) begin
            got = '0;
            for (int b = 0; b < 12; b++) begin
                got = {got[10:0], data};
                if (!(j == FW - 1 && b == 11)) begin
                    wait_cdr();
                    wait_cdr();
                    #100;
                end
            end
            pat(mode, j, e, o, m1, m2, w);
            chk($sformatf("word_m%0d_%0d", mode, j), got, w);
        end
        adc_in = post_adc;
        wait_cdr();
        chk("end_idle", {data, next_data}, 0);
    endtask

    initial begin
        bit ok;
        int base;

        // idle after reset: divider waveform, everything else quiet
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            chk($sformatf("cdiv_%0d", i), clk_div_16, (i / 8) % 2);
            chk($sformatf("idle_%0d", i), {next_data, data, mag_out1, mag_out2}, 0);
        end

        do_reset(); feed(0); rx(0, 12'd2048);
        do_reset(); feed(1); rx(1, 12'd2048);
        do_reset(); feed(2); rx(2, 12'd2048);

        // reset in the middle of the MSB of word 0
        do_reset();
        feed(1);
        wait_nd(ok);
        wait_cdr();
        wait_cdr();
        wait_cdr();
        #20;
        chk("pre_rst_data", data, 1);
        reset_n = 1'b1;
        #1;
        chk("rst_abort", {data, next_data, clk_div_16, fft_next_out, mag_out1, mag_out2}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        feed(3);
        rx(3, 12'd2048);

        // samples during readout must not leak into either frame
        do_reset();
        base = fft_cnt;
        feed(2);
        adc_in = 12'd0;
        rx(2, 12'd2148);
        chk("fft_cnt1", fft_cnt - base, 1);
        rx(4, 12'd2048);
        chk("fft_cnt2", fft_cnt - base, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/radar_top.md
RADAR_TOP -- requirements
Module: radar_top

Interface
REQ-001 SHALL have parameters: ADC_W default 12, sample width; FRAME_WORDS default 2048, words per frame; CLK_DIV default 16, serial clock divide ratio; BIT_SER_CYCLES default 2, clk_div_16 periods per serial bit.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous active-high reset (asserted at 1, despite the name).
REQ-004 SHALL have port: adc_in  input  12  unsigned offset-binary ADC sample, mid-scale 2048.
REQ-005 SHALL have port: mag_out1  output  12  magnitude of even sample of current pair.
REQ-006 SHALL have port: mag_out2  output  12  magnitude of odd sample of current pair.
REQ-007 SHALL have port: fft_next_out  output  1  one-clk pulse marking pair 0 of a captured frame.
REQ-008 SHALL have port: next_data  output  1  frame-start flag of serial stream.
REQ-009 SHALL have port: data  output  1  serial data, MSB first.
REQ-010 SHALL have port: clk_div_16  output  1  serial clock, clk/16, 50% duty.

Function
REQ-011 clk_div_16 SHALL be a free-running 4-bit counter MSB: toggles every 8 clk, first rising edge 8 clk after reset release.
REQ-012 A sample strobe SHALL fire every 2nd clk (first strobe on the 2nd clk after reset release); adc_in is registered only on strobe.
REQ-013 Magnitude SHALL be |x - 2048| computed at 13 bits, saturated to 12 bits (x=0 -> 2048, x=4095 -> 2047, x=2048 -> 0).
REQ-014 Samples SHALL be paired (even, odd); 1 clk after the odd strobe, mag_out1/mag_out2 update and hold until the next pair.
REQ-015 During CAPTURE, word k = max(mag_out1, mag_out2) of pair k SHALL be written to a 2048x12 buffer, k = 0..2047; fft_next_out pulses with pair 0 update.
REQ-016 States: CAPTURE -> SYNC after pair 2047 is written; SYNC -> START at the next clk_div_16 rising edge; START (next_data=1) lasts 1 clk_div_16 period; LEAD (data=0) lasts 1 period; SHIFT -> CAPTURE after last bit.
REQ-017 In SHIFT, words 0..2047 SHALL be output MSB first, each bit held BIT_SER_CYCLES clk_div_16 periods (32 clk), transitions on clk_div_16 rising edges; first bit starts 2 clk_div_16 periods after next_data rise.
REQ-018 Outside SHIFT, data SHALL be 0; next_data SHALL be 0 outside START.
REQ-019 Samples arriving outside CAPTURE SHALL be discarded (mag_out1/2 still update); new capture starts with the first even sample after returning to CAPTURE.
REQ-020 Frame-complete and clk_div_16 edge coinciding SHALL enter SYNC first (START begins at the following edge).

Reset
REQ-021 Reset SHALL force: all outputs 0, divider 0, state CAPTURE, pair/word/bit counters 0, sample phase even; buffer contents not cleared.
REQ-022 Reset mid-SHIFT SHALL abort the stream immediately (data=0, next_data=0) with no partial completion.

Structure
REQ-023 A shared package SHALL hold: state enum {CAPTURE,SYNC,START,LEAD,SHIFT}, ADC_MID=2048, WORD_W=12, FRAME_WORDS, CLK_DIV, BIT_SER_CYCLES.
REQ-024 One sub-module radar_serializer SHALL implement SYNC..SHIFT, buffer read and bit shifting; capture/magnitude stay in radar_top.

Verification
REQ-025 Reset then idle 64 clk -> clk_div_16 period 16 clk, first rise at clk 8; all other outputs 0.
REQ-026 adc_in held 2048 for one frame -> mag_out1=mag_out2=0, next_data pulses 16 clk wide, 24576 serial bits all 0.
REQ-027 Alternating pair samples 0,4095 -> mag_out1=2048, mag_out2=2047; every serialized word 100000000000.
REQ-028 Ramp word k = k+2048 (both samples of pair k) -> serialized word k equals k; bit sampled 3 clk_div_16 edges + 100 ns after next_data rise, then every 2 edges, matches MSB-first.
REQ-029 Assert reset_n mid-SHIFT for 3 clk -> data and next_data 0 within 0 clk; after release new capture, full frame emitted correctly.
REQ-030 Samples applied during SHIFT -> ignored; second frame reflects only post-SHIFT samples; fft_next_out pulses once per captured frame.
